// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - synchronised reset request with minimum hold and staged domain release
// Holds every domain in reset for HOLD_CYCLES after the last request, then releases them in index order.
module rst_sequencer #(
   parameter int NUM_DOMAINS = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ext_rst_n,
   input  logic                   soft_rst,
   output logic [NUM_DOMAINS-1:0] sys_rst_n,
   output logic                   rst_done,
   output logic                   busy
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

   localparam logic [1:0] ST_HOLD    = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ext_sync;
   logic                   req;
   logic [1:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;

   // Reset clears the chain to the asserted level so a pin that is already high still waits out the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
      end
   end

   assign ext_sync = sync_q[SYNC_STAGES-1];
   assign req      = ~ext_sync | soft_rst;

   always_ff @(posedge clk) begin
      if (rst || req) begin
         state     <= ST_HOLD;
         cnt       <= '0;
         idx       <= '0;
         sys_rst_n <= '0;
         rst_done  <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt          <= '0;
                  sys_rst_n[0] <= 1'b1;
                  if (NUM_DOMAINS == 1) begin
                     state    <= ST_RUN;
                     rst_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state <= ST_RELEASE;
                     idx   <= IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt == STEP_LAST) begin
                  cnt <= '0;
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (IDX_W'(i) == idx) begin
                        sys_rst_n[i] <= 1'b1;
                     end
                  end
                  if (idx == IDX_LAST) begin
                     state    <= ST_RUN;
                     rst_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
            end
            // An unreachable encoding restarts the sequence from a fully asserted state.
            default: begin
               state     <= ST_HOLD;
               cnt       <= '0;
               idx       <= '0;
               sys_rst_n <= '0;
               rst_done  <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule
